// File: rtl/tile_dispatcher_pkg.sv
// tile_dispatcher_pkg: definitions shared by the dispatcher, processor and CU tiles.
// Holds the block index width and the dispatcher FSM encodings.
package tile_dispatcher_pkg;

   localparam int INDEX_WIDTH = 8;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SELECT = 3'd1,
      S_ISSUE  = 3'd2,
      S_DRAIN  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

endpackage

// File: rtl/tile_dispatcher_if.sv
// tile_dispatcher_if: shared index bus between the dispatcher and the tiles.
// Row/col/mu plus one-hot index_ready go out; per-tile ack and result_ready come back.
interface tile_dispatcher_if
   import tile_dispatcher_pkg::*;
#(
   parameter int num_proc    = 4,
   parameter int index_width = INDEX_WIDTH
);

   logic [index_width-1:0] out_row_index;
   logic [index_width-1:0] out_col_index;
   logic [index_width-1:0] out_mu;
   logic [num_proc-1:0]    out_index_ready;
   logic [num_proc-1:0]    in_index_ack;
   logic [num_proc-1:0]    in_result_ready;

   modport master (
      output out_row_index,
      output out_col_index,
      output out_mu,
      output out_index_ready,
      input  in_index_ack,
      input  in_result_ready
   );

   modport slave (
      input  out_row_index,
      input  out_col_index,
      input  out_mu,
      input  out_index_ready,
      output in_index_ack,
      output in_result_ready
   );

endinterface

// File: rtl/tile_dispatcher_free_tile_picker.sv
// tile_dispatcher_free_tile_picker: lowest-index priority encoder over free tiles.
// Ports: i_free (free mask), o_valid (any free), o_grant (one-hot lowest free).
module tile_dispatcher_free_tile_picker #(
   parameter int num_proc = 4
) (
   input  logic [num_proc-1:0] i_free,
   output logic                o_valid,
   output logic [num_proc-1:0] o_grant
);

   assign o_valid = |i_free;

   // Scan from the top down so the lowest free index is written last.
   always_comb begin
      o_grant = '0;
      for (int k = num_proc - 1; k >= 0; k--) begin
         if (i_free[k]) begin
            o_grant    = '0;
            o_grant[k] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tile_dispatcher.sv
// tile_dispatcher: walks the C block grid row-major, issues each (i,j) to a free tile,
// counts result_ready completions. Ports: in_clk/in_reset, in_start/in_grid/in_mu, out_busy/out_done, bus.
module tile_dispatcher
   import tile_dispatcher_pkg::*;
#(
   parameter int num_proc    = 4,
   parameter int index_width = INDEX_WIDTH
) (
   input  logic                   in_clk,
   input  logic                   in_reset,
   input  logic                   in_start,
   input  logic [index_width-1:0] in_grid,
   input  logic [index_width-1:0] in_mu,
   output logic                   out_busy,
   output logic                   out_done,
   tile_dispatcher_if.master      bus
);

   localparam int CW = 2 * index_width;
   localparam logic [index_width-1:0] IDX_ONE = index_width'(1);

   state_t                 r_state;
   logic [index_width-1:0] r_grid;
   logic [index_width-1:0] r_mu;
   logic [index_width-1:0] r_row;
   logic [index_width-1:0] r_col;
   logic [index_width-1:0] r_bus_row;
   logic [index_width-1:0] r_bus_col;
   logic [num_proc-1:0]    r_busy_mask;
   logic [num_proc-1:0]    r_index_ready;
   logic [CW-1:0]          r_completed;
   logic                   r_busy;
   logic                   r_done;

   logic [num_proc-1:0]    w_free;
   logic [num_proc-1:0]    w_grant;
   logic                   w_valid;
   logic [num_proc-1:0]    w_retire;
   logic [num_proc-1:0]    w_acked;
   logic [CW-1:0]          w_retire_cnt;
   logic [CW-1:0]          w_total;
   logic [index_width-1:0] w_grid_m1;
   logic                   w_col_wrap;
   logic                   w_last;

   // A tile still showing result_ready is not free, so one
   // completion can never be counted twice.
   assign w_free     = ~(r_busy_mask | bus.in_result_ready);
   assign w_retire   = (r_state == S_IDLE) ? '0
                     : (r_busy_mask & bus.in_result_ready);
   assign w_acked    = r_index_ready & bus.in_index_ack;
   assign w_total    = CW'(r_grid) * CW'(r_grid);
   assign w_grid_m1  = r_grid - IDX_ONE;
   assign w_col_wrap = (r_col == w_grid_m1);
   assign w_last     = w_col_wrap && (r_row == w_grid_m1);

   always_comb begin
      w_retire_cnt = '0;
      for (int k = 0; k < num_proc; k++) begin
         w_retire_cnt = w_retire_cnt + CW'(w_retire[k]);
      end
   end

   tile_dispatcher_free_tile_picker #(
      .num_proc (num_proc)
   ) u_picker (
      .i_free  (w_free),
      .o_valid (w_valid),
      .o_grant (w_grant)
   );

   always_ff @(posedge in_clk or posedge in_reset) begin
      if (in_reset) begin
         r_state       <= S_IDLE;
         r_grid        <= '0;
         r_mu          <= '0;
         r_row         <= '0;
         r_col         <= '0;
         r_bus_row     <= '0;
         r_bus_col     <= '0;
         r_busy_mask   <= '0;
         r_index_ready <= '0;
         r_completed   <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_busy_mask <= r_busy_mask & ~w_retire;
         r_completed <= r_completed + w_retire_cnt;
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (in_start) begin
                  r_grid      <= in_grid;
                  r_mu        <= in_mu;
                  r_row       <= '0;
                  r_col       <= '0;
                  r_busy_mask <= '0;
                  r_completed <= '0;
                  if (in_grid == '0) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_SELECT;
                     r_busy  <= 1'b1;
                     r_done  <= 1'b0;
                  end
               end
            end
            S_SELECT: begin
               if (w_valid) begin
                  r_bus_row     <= r_row;
                  r_bus_col     <= r_col;
                  r_index_ready <= w_grant;
                  r_state       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (|w_acked) begin
                  r_index_ready <= '0;
                  r_busy_mask   <= (r_busy_mask & ~w_retire)
                                 | r_index_ready;
                  if (w_col_wrap) begin
                     r_col <= '0;
                     r_row <= r_row + IDX_ONE;
                  end else begin
                     r_col <= r_col + IDX_ONE;
                  end
                  r_state <= w_last ? S_DRAIN : S_SELECT;
               end
            end
            S_DRAIN: begin
               if (r_completed == w_total) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.out_row_index   = r_bus_row;
   assign bus.out_col_index   = r_bus_col;
   assign bus.out_mu          = r_mu;
   assign bus.out_index_ready = r_index_ready;
   assign out_busy            = r_busy;
   assign out_done            = r_done;

endmodule

// File: tb/tb_tile_dispatcher.sv
// tb_tile_dispatcher: directed bench for tile_dispatcher with 4-tile and 1-tile instances.
// Table-driven dispatch runs plus hand-written reset, ack-delay and completion sequences.
module tb_tile_dispatcher;
   import tile_dispatcher_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       start4, start1;
   logic [7:0] grid4, mu4, grid1, mu1;
   logic       busy4, done4, busy1, done1;

   tile_dispatcher_if #(.num_proc(4), .index_width(8)) bus4();
   tile_dispatcher_if #(.num_proc(1), .index_width(8)) bus1();

   tile_dispatcher #(.num_proc(4), .index_width(8)) dut4 (
      .in_clk   (clk),
      .in_reset (rst),
      .in_start (start4),
      .in_grid  (grid4),
      .in_mu    (mu4),
      .out_busy (busy4),
      .out_done (done4),
      .bus      (bus4)
   );

   tile_dispatcher #(.num_proc(1), .index_width(8)) dut1 (
      .in_clk   (clk),
      .in_reset (rst),
      .in_start (start1),
      .in_grid  (grid1),
      .in_mu    (mu1),
      .out_busy (busy1),
      .out_done (done1),
      .bus      (bus1)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] row;
      logic [7:0] col;
      logic [3:0] rdy;
   } disp_t;

   typedef struct {
      logic [7:0] grid;
      logic [7:0] mu;
      int         first;
      int         n;
   } run_t;

   disp_t vec[13];
   run_t  runs[2];
   disp_t got[$];

   int total = 0;
   int bad   = 0;

   int ts[4];
   int tc[4];
   int ack_dly  = 1;
   int res_dly  = 10;
   int res_hold = 2;
   int n_res, onehot_err, reissue_err;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Behavioural tile set: ack after ack_dly, result after res_dly,
   // result held for res_hold cycles.
   task automatic auto_step();
      disp_t d;
      if ($countones(bus4.out_index_ready) > 1) onehot_err++;
      for (int p = 0; p < 4; p++) begin
         case (ts[p])
            0: begin
               bus4.in_index_ack[p] = 1'b0;
               if (bus4.out_index_ready[p]) begin
                  tc[p]++;
                  if (tc[p] >= ack_dly) begin
                     bus4.in_index_ack[p] = 1'b1;
                     d.row = bus4.out_row_index;
                     d.col = bus4.out_col_index;
                     d.rdy = bus4.out_index_ready;
                     got.push_back(d);
                     ts[p] = 1;
                     tc[p] = 0;
                  end
               end
            end
            1: begin
               bus4.in_index_ack[p] = 1'b0;
               if (bus4.out_index_ready[p]) reissue_err++;
               tc[p]++;
               if (tc[p] >= res_dly) begin
                  bus4.in_result_ready[p] = 1'b1;
                  n_res++;
                  ts[p] = 2;
                  tc[p] = 0;
               end
            end
            default: begin
               if (bus4.out_index_ready[p]) reissue_err++;
               tc[p]++;
               if (tc[p] >= res_hold) begin
                  bus4.in_result_ready[p] = 1'b0;
                  ts[p] = 0;
                  tc[p] = 0;
               end
            end
         endcase
      end
   endtask

   task automatic issue4(input int tile, input logic [7:0] row,
                         input logic [7:0] col);
      int seen = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (bus4.out_index_ready != '0) begin
            seen = 1;
            break;
         end
      end
      chk("m_seen", seen, 1);
      chk("m_rdy", bus4.out_index_ready, 4'b0001 << tile);
      chk("m_row", bus4.out_row_index, row);
      chk("m_col", bus4.out_col_index, col);
      bus4.in_index_ack = 4'b0001 << tile;
      @(negedge clk);
      bus4.in_index_ack = '0;
      chk("m_rdy_clr", bus4.out_index_ready, 0);
   endtask

   task automatic pulse4(input logic [3:0] mask);
      bus4.in_result_ready = mask;
      @(negedge clk);
      bus4.in_result_ready = '0;
   endtask

   initial begin
      int seen, res_at_done, stable_bad, blk_bad;

      vec[0]  = '{8'd0, 8'd0, 4'b0001};
      vec[1]  = '{8'd0, 8'd1, 4'b0010};
      vec[2]  = '{8'd1, 8'd0, 4'b0100};
      vec[3]  = '{8'd1, 8'd1, 4'b1000};
      vec[4]  = '{8'd0, 8'd0, 4'b0001};
      vec[5]  = '{8'd0, 8'd1, 4'b0010};
      vec[6]  = '{8'd0, 8'd2, 4'b0100};
      vec[7]  = '{8'd1, 8'd0, 4'b1000};
      vec[8]  = '{8'd1, 8'd1, 4'b0001};
      vec[9]  = '{8'd1, 8'd2, 4'b0010};
      vec[10] = '{8'd2, 8'd0, 4'b0100};
      vec[11] = '{8'd2, 8'd1, 4'b1000};
      vec[12] = '{8'd2, 8'd2, 4'b0001};
      runs[0] = '{8'd2, 8'd3, 0, 4};
      runs[1] = '{8'd3, 8'd7, 4, 9};

      rst = 1'b1;
      start4 = 1'b0; grid4 = '0; mu4 = '0;
      start1 = 1'b0; grid1 = '0; mu1 = '0;
      bus4.in_index_ack = '0; bus4.in_result_ready = '0;
      bus1.in_index_ack = '0; bus1.in_result_ready = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      chk("rst_busy", busy4, 0);
      chk("rst_done", done4, 0);
      chk("rst_rdy", bus4.out_index_ready, 0);
      chk("rst_row", bus4.out_row_index, 0);
      chk("rst_col", bus4.out_col_index, 0);
      chk("rst_mu", bus4.out_mu, 0);
      chk("rst_state", dut4.r_state, S_IDLE);

      // grid == 0 finishes without issuing anything
      grid4 = 8'd0; mu4 = 8'd9; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      chk("g0_done1", done4, 1);
      chk("g0_busy", busy4, 0);
      chk("g0_rdy1", bus4.out_index_ready, 0);
      @(negedge clk);
      chk("g0_done2", done4, 1);
      chk("g0_rdy2", bus4.out_index_ready, 0);

      // reset while tile 0 is being offered a block
      grid4 = 8'd2; mu4 = 8'd5; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      chk("lat_rdy_e1", bus4.out_index_ready, 0);
      chk("lat_done_clr", done4, 0);
      @(negedge clk);
      chk("lat_rdy_e2", bus4.out_index_ready, 4'b0001);
      chk("lat_mu", bus4.out_mu, 5);
      chk("lat_busy", busy4, 1);
      rst = 1'b1;
      #1;
      chk("mr_rdy", bus4.out_index_ready, 0);
      chk("mr_busy", busy4, 0);
      chk("mr_done", done4, 0);
      chk("mr_mu", bus4.out_mu, 0);
      chk("mr_state", dut4.r_state, S_IDLE);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // table-driven runs with the automatic tile model
      for (int r = 0; r < 2; r++) begin
         got.delete();
         n_res = 0; onehot_err = 0; reissue_err = 0;
         for (int p = 0; p < 4; p++) begin
            ts[p] = 0;
            tc[p] = 0;
         end
         grid4 = runs[r].grid; mu4 = runs[r].mu; start4 = 1'b1;
         @(negedge clk);
         start4 = 1'b0;
         seen = 0; res_at_done = -1;
         for (int c = 0; c < 400 && seen == 0; c++) begin
            @(negedge clk);
            if (done4) begin
               seen = 1;
               res_at_done = n_res;
            end else begin
               auto_step();
            end
         end
         repeat (6) begin
            @(negedge clk);
            auto_step();
         end
         chk("run_done_seen", seen, 1);
         chk("run_res_at_done", res_at_done, runs[r].n);
         chk("run_ndisp", got.size(), runs[r].n);
         for (int i = 0; i < runs[r].n; i++) begin
            if (i < got.size()) begin
               chk("run_row", got[i].row, vec[runs[r].first + i].row);
               chk("run_col", got[i].col, vec[runs[r].first + i].col);
               chk("run_tile", got[i].rdy, vec[runs[r].first + i].rdy);
            end
         end
         chk("run_mu", bus4.out_mu, runs[r].mu);
         chk("run_busy", busy4, 0);
         chk("run_completed", dut4.r_completed, runs[r].n);
         chk("run_onehot", onehot_err, 0);
         chk("run_reissue", reissue_err, 0);
      end
      bus4.in_index_ack = '0;
      bus4.in_result_ready = '0;
      @(negedge clk);

      // manual grid=3 run: slow ack, spurious ack/start, paired completion
      grid4 = 8'd3; mu4 = 8'd2; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      issue4(0, 8'd0, 8'd0);
      issue4(1, 8'd0, 8'd1);
      seen = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (bus4.out_index_ready != '0) begin
            seen = 1;
            break;
         end
      end
      chk("d_seen", seen, 1);
      chk("d_rdy", bus4.out_index_ready, 4'b0100);
      chk("d_col", bus4.out_col_index, 2);
      stable_bad = 0;
      for (int c = 0; c < 50; c++) begin
         if (c == 10) begin
            bus4.in_index_ack = 4'b0001;
            start4 = 1'b1;
            grid4 = 8'd5;
         end
         if (c == 11) begin
            bus4.in_index_ack = '0;
            start4 = 1'b0;
            grid4 = 8'd3;
         end
         @(negedge clk);
         if (bus4.out_index_ready !== 4'b0100 ||
             bus4.out_row_index !== 8'd0 ||
             bus4.out_col_index !== 8'd2 || busy4 !== 1'b1)
            stable_bad++;
      end
      chk("d_stable", stable_bad, 0);
      bus4.in_index_ack = 4'b0100;
      @(negedge clk);
      bus4.in_index_ack = '0;
      chk("d_rdy_clr", bus4.out_index_ready, 0);
      issue4(3, 8'd1, 8'd0);
      repeat (3) @(negedge clk);
      chk("all_busy_rdy", bus4.out_index_ready, 0);

      bus4.in_result_ready = 4'b1010;
      @(negedge clk);
      chk("pair_completed", dut4.r_completed, 2);
      blk_bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus4.out_index_ready !== 4'b0000 ||
             dut4.r_completed !== 16'd2)
            blk_bad++;
      end
      chk("pair_hold", blk_bad, 0);
      bus4.in_result_ready = '0;
      issue4(1, 8'd1, 8'd1);
      issue4(3, 8'd1, 8'd2);
      repeat (2) @(negedge clk);
      pulse4(4'b1111);
      chk("m_completed6", dut4.r_completed, 6);
      issue4(0, 8'd2, 8'd0);
      issue4(1, 8'd2, 8'd1);
      issue4(2, 8'd2, 8'd2);
      @(negedge clk);
      chk("drain_busy", busy4, 1);
      chk("drain_done", done4, 0);
      pulse4(4'b0111);
      seen = 0;
      for (int c = 0; c < 20 && seen == 0; c++) begin
         @(negedge clk);
         if (done4) seen = 1;
      end
      chk("m_done", seen, 1);
      chk("m_completed9", dut4.r_completed, 9);
      chk("m_busy", busy4, 0);

      // single tile: every dispatch waits for the previous result
      grid1 = 8'd2; mu1 = 8'd4; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         seen = 0;
         for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus1.out_index_ready != '0) begin
               seen = 1;
               break;
            end
         end
         chk("s_seen", seen, 1);
         chk("s_row", bus1.out_row_index, vec[k].row);
         chk("s_col", bus1.out_col_index, vec[k].col);
         bus1.in_index_ack = 1'b1;
         @(negedge clk);
         bus1.in_index_ack = 1'b0;
         blk_bad = 0;
         repeat (3) begin
            @(negedge clk);
            if (bus1.out_index_ready !== 1'b0) blk_bad++;
         end
         bus1.in_result_ready = 1'b1;
         repeat (3) begin
            @(negedge clk);
            if (bus1.out_index_ready !== 1'b0) blk_bad++;
         end
         bus1.in_result_ready = 1'b0;
         chk("s_wait", blk_bad, 0);
      end
      seen = 0;
      for (int c = 0; c < 20 && seen == 0; c++) begin
         @(negedge clk);
         if (done1) seen = 1;
      end
      chk("s_done", seen, 1);
      chk("s_completed", dut1.r_completed, 4);
      chk("s_mu", bus1.out_mu, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
